// File: rtl/fp_addsub_arbiter_if.sv
// Client-side bus of fp_addsub_arbiter.
//   req_valid/req_ready : per-requester handshake, transfer on valid & ready
//   req_a/req_b         : 32-bit operands, slice i = [32*i+31:32*i]
//   req_op              : per-requester operation, 0 = add, 1 = subtract
//   rsp_valid           : one-cycle pulse to the requester that owns the result
//   rsp_result/rsp_flags: shared result and flags {OVF,UNF,DBZ,INV,INX}
// master = compute clients, slave = arbiter.
interface fp_addsub_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_op;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_result;
  logic [4:0]            rsp_flags;

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: shares one pipelined FPAddSub unit (no stall input)
// between NUM_REQ requesters.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   bus        : client bus (slave modport), request handshake/operands and
//                tagged response pulses
//   fpu_a/b/op : operands and operation to the FPU, zero when nothing issues
//   fpu_result : FPU result, LATENCY clocks after its operands
//   fpu_flags  : FPU flags {OVF,UNF,DBZ,INV,INX}
//   busy       : any issued operation still in flight
// Round-robin grant, one issue per clock, requester id carried down a tag
// pipe matched to the FPU latency, per-requester outstanding limit.
// Build option FPARB_FIXED_PRIO_EN: requester 0 gets strict priority and its
// grants do not move the round-robin pointer.
module fp_addsub_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 10,
  parameter int OUTST_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  fp_addsub_arbiter_if.slave  bus,
  output logic [31:0]         fpu_a,
  output logic [31:0]         fpu_b,
  output logic                fpu_op,
  input  logic [31:0]         fpu_result,
  input  logic [4:0]          fpu_flags,
  output logic                busy
);

  localparam int unsigned NR    = NUM_REQ;
  localparam int unsigned LAT   = LATENCY;
  localparam int          ID_W  = 3;
  localparam int          CNT_W = 4;

  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt [NUM_REQ];
  logic [LAT-1:0]   tag_vld;
  logic [ID_W-1:0]  tag_id [LATENCY];

  logic [NR-1:0]    elig;
  logic             grant_any;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  rr_next;
  logic             last_vld;
  logic [ID_W-1:0]  last_id;

  assign last_vld = tag_vld[LAT-1];
  assign last_id  = tag_id[LAT-1];

  // Eligibility uses the registered count, so a same-cycle response only
  // re-enables a saturated requester from the next cycle. Gating with rst
  // keeps every grant-derived output at zero while reset is held.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      elig[i] = rst && bus.req_valid[i] && (cnt[i] < CNT_W'(OUTST_MAX));
    end
  end

  // Wrap-around search from rr_ptr done as two ordered passes: ids at or
  // above the pointer first, then ids below it.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
`ifdef FPARB_FIXED_PRIO_EN
    if (elig[0]) begin
      grant_any = 1'b1;
      grant_id  = '0;
    end
`endif
    for (int unsigned i = 0; i < NR; i++) begin
      if (!grant_any && elig[i] && (ID_W'(i) >= rr_ptr)) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NR; i++) begin
      if (!grant_any && elig[i] && (ID_W'(i) < rr_ptr)) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    rr_next = rr_ptr;
    if (grant_any) begin
      if (grant_id == ID_W'(NR - 1)) rr_next = '0;
      else                           rr_next = grant_id + 1'b1;
`ifdef FPARB_FIXED_PRIO_EN
      if (grant_id == '0) rr_next = rr_ptr;
`endif
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      bus.req_ready[i] = grant_any && (grant_id == ID_W'(i));
      bus.rsp_valid[i] = last_vld && (last_id == ID_W'(i));
    end
  end

  always_comb begin
    fpu_a  = '0;
    fpu_b  = '0;
    fpu_op = 1'b0;
    if (grant_any) begin
      fpu_a  = bus.req_a[32*grant_id +: 32];
      fpu_b  = bus.req_b[32*grant_id +: 32];
      fpu_op = bus.req_op[grant_id];
    end
  end

  assign bus.rsp_result = fpu_result;
  assign bus.rsp_flags  = fpu_flags;
  assign busy           = |tag_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      tag_vld <= '0;
      for (int unsigned s = 0; s < LAT; s++) tag_id[s] <= '0;
    end else begin
      rr_ptr    <= rr_next;
      tag_vld   <= {tag_vld[LAT-2:0], grant_any};
      tag_id[0] <= grant_id;
      for (int unsigned s = 1; s < LAT; s++) tag_id[s] <= tag_id[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NR; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NR; i++) begin
        case ({bus.req_ready[i], bus.rsp_valid[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Testbench for fp_addsub_arbiter: a 10-stage FPU stand-in, per-requester
// drivers, and a negedge monitor that scoreboards every issue against the
// response it must produce.
module tb_fp_addsub_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_arbiter_if #(.NUM_REQ(NR)) bus();

  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic        fpu_op;
  logic [4:0]  fpu_flags;
  logic        busy;

  fp_addsub_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .OUTST_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_result (fpu_result),
    .fpu_flags  (fpu_flags),
    .busy       (busy)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; logic op; } op_t;
  typedef struct { int id; logic [31:0] res; logic [4:0] flg; int due; } exp_t;
  typedef struct { int id; int cyc; } gnt_t;

  op_t  pend [NR][$];
  exp_t sb [$];
  gnt_t glog [$];

  int checks = 0, failures = 0, cyc = 0;
  int rsp_count = 0, last_rsp_cyc = 0;
  logic [NR-1:0] fired = '0;
  logic [NR-1:0] last_rsp_vec = '0;
  logic [31:0]   last_rsp_res = '0;
  logic [4:0]    last_rsp_flg = '0;

  // FPU stand-in: the two directed vectors give true IEEE results, anything
  // else a deterministic integer signature.
  function automatic logic [36:0] fpu_fn(logic [31:0] a, logic [31:0] b, logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && !op) return {5'd0, 32'h40400000};
    if (a == 32'h40A00000 && b == 32'h40400000 && op)  return {5'd0, 32'h40000000};
    return {op, a[3:0] ^ b[3:0], op ? (a - b) : (a + b)};
  endfunction

  logic [64:0] fpipe [LAT];
  initial for (int k = 0; k < LAT; k++) fpipe[k] = '0;
  always @(posedge clk) begin
    fpipe[0] <= {fpu_op, fpu_a, fpu_b};
    for (int k = 1; k < LAT; k++) fpipe[k] <= fpipe[k-1];
  end
  assign {fpu_flags, fpu_result} = fpu_fn(fpipe[LAT-1][63:32], fpipe[LAT-1][31:0], fpipe[LAT-1][64]);

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic [NR-1:0] fire;
    int   gid;
    exp_t e;
    logic [36:0] fr;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        sb.delete();
        fired = '0;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fpu_a", fpu_a, 0);
        check("rst_fpu_op", fpu_op, 0);
      end else begin
        check("busy", busy, sb.size() != 0);
        check("ready_onehot0", $onehot0(bus.req_ready), 1);
        check("ready_without_valid", (bus.req_ready & ~bus.req_valid) != 0, 0);
        fire = bus.req_valid & bus.req_ready;
        if (fire != 0) begin
          gid = 0;
          for (int i = 0; i < NR; i++) if (fire[i]) gid = i;
          check("fpu_a_mux", fpu_a, bus.req_a[32*gid +: 32]);
          check("fpu_b_mux", fpu_b, bus.req_b[32*gid +: 32]);
          check("fpu_op_mux", fpu_op, bus.req_op[gid]);
          fr = fpu_fn(bus.req_a[32*gid +: 32], bus.req_b[32*gid +: 32], bus.req_op[gid]);
          sb.push_back('{id: gid, res: fr[31:0], flg: fr[36:32], due: cyc + LAT});
          glog.push_back('{id: gid, cyc: cyc});
        end else begin
          check("fpu_idle_zero", {fpu_op, fpu_a, fpu_b} != 0, 0);
        end
        if (bus.rsp_valid != 0) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", bus.rsp_valid, 0);
          end else begin
            e = sb.pop_front();
            check("rsp_owner", bus.rsp_valid, NR'(1) << e.id);
            check("rsp_result", bus.rsp_result, e.res);
            check("rsp_flags", bus.rsp_flags, e.flg);
            check("rsp_latency", cyc, e.due);
          end
          rsp_count++;
          last_rsp_cyc = cyc;
          last_rsp_vec = bus.rsp_valid;
          last_rsp_res = bus.rsp_result;
          last_rsp_flg = bus.rsp_flags;
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
          check("rsp_missing", 0, 1);
          void'(sb.pop_front());
        end
        fired = fire;
      end
    end
  end

  // Request drivers: hold operands until the monitor has seen the transfer.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (fired[i] && pend[i].size() > 0) pend[i].delete(0);
        if (pend[i].size() > 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_a[32*i +: 32]  = pend[i][0].a;
          bus.req_b[32*i +: 32]  = pend[i][0].b;
          bus.req_op[i]          = pend[i][0].op;
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_a[32*i +: 32]  = '0;
          bus.req_b[32*i +: 32]  = '0;
          bus.req_op[i]          = 1'b0;
        end
      end
    end
  end

  task automatic enq(int i, logic [31:0] a, logic [31:0] b, logic op);
    op_t o;
    o.a = a; o.b = b; o.op = op;
    pend[i].push_back(o);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (pend[i].size() > 0) return 1'b1;
    return sb.size() != 0;
  endfunction

  task automatic wait_idle(int budget);
    int n = 0;
    while (pending() && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", pending(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, n;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    do_reset();

    // 1: single add on requester 0
    glog.delete();
    r0 = rsp_count;
    enq(0, 32'h3F800000, 32'h40000000, 1'b0);
    wait_idle(100);
    check("t1_grants", glog.size(), 1);
    check("t1_rsps", rsp_count - r0, 1);
    check("t1_vec", last_rsp_vec, 4'b0001);
    check("t1_result", last_rsp_res, 32'h40400000);
    check("t1_flags", last_rsp_flg, 0);
    check("t1_latency", last_rsp_cyc - glog[0].cyc, 10);

    // 2: all four requesters busy, grants rotate 0,1,2,3
    do_reset();
    glog.delete();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NR; i++)
        enq(i, 32'h01000000 * (i + 1) + k, 32'h10 * k + i, 1'((i + k) & 1));
    wait_idle(200);
    check("t2_grants", glog.size(), 12);
    for (int k = 0; k < 12; k++) begin
      check("t2_order", glog[k].id, k % 4);
      check("t2_back_to_back", glog[k].cyc - glog[0].cyc, k);
    end

    // 3: outstanding limit on requester 1
    do_reset();
    glog.delete();
    for (int k = 0; k < 5; k++) enq(1, 32'h00000100 + k, 32'h00000003, 1'b0);
    wait_idle(200);
    check("t3_grants", glog.size(), 5);
    check("t3_fourth", glog[3].cyc - glog[0].cyc, 3);
    check("t3_regrant", glog[4].cyc - glog[0].cyc, 11);

    // 4: subtract on requester 2
    glog.delete();
    enq(2, 32'h40A00000, 32'h40400000, 1'b1);
    wait_idle(100);
    check("t4_vec", last_rsp_vec, 4'b0100);
    check("t4_result", last_rsp_res, 32'h40000000);
    check("t4_flags", last_rsp_flg, 0);

    // 5: reset with three operations in flight
    do_reset();
    glog.delete();
    enq(0, 32'h11, 32'h22, 1'b0);
    enq(1, 32'h33, 32'h44, 1'b1);
    enq(2, 32'h55, 32'h66, 1'b0);
    n = 0;
    while (glog.size() < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_issued", glog.size(), 3);
    repeat (5) @(negedge clk);
    r0 = rsp_count;
    do_reset();
    check("t5_busy_after_rst", busy, 0);
    repeat (20) @(negedge clk);
    check("t5_no_rsp", rsp_count - r0, 0);
    glog.delete();
    for (int k = 0; k < 4; k++) enq(0, 32'h200 + k, 32'h7, 1'b0);
    wait_idle(200);
    check("t5_cnt_cleared", glog.size(), 4);
    check("t5_four_back_to_back", glog[3].cyc - glog[0].cyc, 3);

    // 6: requesters 0 and 3 always valid
    do_reset();
    glog.delete();
    for (int k = 0; k < 6; k++) begin
      enq(0, 32'h300 + k, 32'h1, 1'b0);
      enq(3, 32'h400 + k, 32'h2, 1'b1);
    end
    wait_idle(300);
    check("t6_grants", glog.size(), 12);
    for (int k = 0; k < 8; k++) begin
`ifdef FPARB_FIXED_PRIO_EN
      check("t6_order", glog[k].id, (k < 4) ? 0 : 3);
`else
      check("t6_order", glog[k].id, (k % 2 == 1) ? 3 : 0);
`endif
      check("t6_back_to_back", glog[k].cyc - glog[0].cyc, k);
    end
    check("t6_regrant_id", glog[8].id, 0);
    check("t6_regrant_cyc", glog[8].cyc - glog[0].cyc, 11);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
